// File: rtl/beam_sum_scheduler_pkg.sv
// beam_sum_scheduler_pkg: shared sizes, FSM state and delay-index types for the beam summer
package beam_sum_scheduler_pkg;
    localparam int NUMBER_OF_BITS = 16;
    localparam int BUFFER_SIZE = 8;
    localparam int NUM_CH = 4;
    localparam int IDX_W = $clog2(BUFFER_SIZE);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int ACC_W = NUMBER_OF_BITS + CH_W;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
    typedef logic [IDX_W-1:0] dly_t;
endpackage

// File: rtl/beam_delay_cfg_regs.sv
// beam_delay_cfg_regs: serial shadow delay registers with an active set committed only while idle
module beam_delay_cfg_regs
    import beam_sum_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CH_W-1:0]         cfg_sel,
    input  logic                    cfg_bit,
    input  logic                    cfg_shift,
    input  logic                    cfg_commit,
    input  logic                    idle,
    output logic [NUM_CH*IDX_W-1:0] active_flat
);
    dly_t shadow [NUM_CH];
    dly_t active [NUM_CH];
    logic pending;
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '{default: '0};
            active <= '{default: '0};
            pending <= 1'b0;
        end else begin
            if (cfg_shift) shadow[cfg_sel] <= {shadow[cfg_sel][IDX_W-2:0], cfg_bit};
            // non-blocking copy takes the pre-shift shadow when shift and commit coincide
            if (idle && (cfg_commit || pending)) active <= shadow;
            pending <= !idle && (cfg_commit || pending);
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_flat
        assign active_flat[i*IDX_W +: IDX_W] = active[i];
    end
endmodule

// File: rtl/beam_sum_scheduler.sv
// beam_sum_scheduler: per-frame delay-and-sum sequencer over one shared buffer read port
// BEAM_SUM_AVG_EN: when defined, sum_data is the channel mean (acc >>> CH_W) instead of the raw sum
module beam_sum_scheduler
    import beam_sum_scheduler_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_strobe,
    input  logic [CH_W-1:0]           cfg_sel,
    input  logic                      cfg_bit,
    input  logic                      cfg_shift,
    input  logic                      cfg_commit,
    input  logic                      ovr_clr,
    output logic                      rd_valid,
    output logic [CH_W-1:0]           rd_ch,
    output logic [IDX_W-1:0]          rd_idx,
    input  logic [NUMBER_OF_BITS-1:0] rd_data,
    output logic [ACC_W-1:0]          sum_data,
    output logic                      sum_valid,
    input  logic                      sum_ready,
    output logic                      busy,
    output logic                      overrun
);
    state_t state, state_nxt;
    logic [CH_W-1:0] ch_cnt;
    logic signed [ACC_W-1:0] acc;
    logic [NUM_CH*IDX_W-1:0] active_flat;
    logic add_en;
    beam_delay_cfg_regs u_cfg (
        .clk         (clk),
        .reset       (reset),
        .cfg_sel     (cfg_sel),
        .cfg_bit     (cfg_bit),
        .cfg_shift   (cfg_shift),
        .cfg_commit  (cfg_commit),
        .idle        (state == IDLE),
        .active_flat (active_flat)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ch_cnt <= '0;
            acc <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            ch_cnt <= (state == RUN) ? ch_cnt + 1'b1 : '0;
            if (state == IDLE && frame_strobe) acc <= '0;
            else if (add_en) acc <= acc + {{CH_W{rd_data[NUMBER_OF_BITS-1]}}, rd_data};
            overrun <= (frame_strobe && state != IDLE) || (overrun && !ovr_clr);
        end
    end
    // data returns one cycle after issue, so adds lag issues by one cycle
    always_comb begin
        add_en = (state == RUN && ch_cnt != '0) || state == DRAIN;
        state_nxt = (state == IDLE && frame_strobe) ? RUN :
                    (state == RUN && ch_cnt == CH_W'(NUM_CH - 1)) ? DRAIN :
                    (state == DRAIN) ? OUT :
                    (state == OUT && sum_ready) ? IDLE : state;
    end
    assign rd_valid = state == RUN;
    assign rd_ch = ch_cnt;
    assign rd_idx = rd_valid ? active_flat[ch_cnt*IDX_W +: IDX_W] : '0;
    assign sum_valid = state == OUT;
    assign busy = state != IDLE;
`ifdef BEAM_SUM_AVG_EN
    assign sum_data = acc >>> CH_W;
`else
    assign sum_data = acc;
`endif
endmodule

// File: tb/tb_beam_sum_scheduler.sv
// tb_beam_sum_scheduler: scoreboard bench with a registered buffer model and a delay-config model
module tb_beam_sum_scheduler;
    import beam_sum_scheduler_pkg::*;
`ifdef BEAM_SUM_AVG_EN
    localparam int EXP1 = 17;
`else
    localparam int EXP1 = 70;
`endif
    logic clk = 0, reset = 1, frame_strobe = 0, cfg_bit = 0, cfg_shift = 0, cfg_commit = 0;
    logic ovr_clr = 0, sum_ready = 1;
    logic [CH_W-1:0] cfg_sel = '0;
    logic rd_valid, sum_valid, busy, overrun;
    logic [CH_W-1:0] rd_ch;
    logic [IDX_W-1:0] rd_idx;
    logic [NUMBER_OF_BITS-1:0] rd_data = '0;
    logic signed [ACC_W-1:0] sum_data;
    logic signed [NUMBER_OF_BITS-1:0] mem [NUM_CH][BUFFER_SIZE];
    int shd [NUM_CH];
    int act [NUM_CH];
    int frame_dly [NUM_CH];
    int sb [$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    beam_sum_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .frame_strobe (frame_strobe),
        .cfg_sel      (cfg_sel),
        .cfg_bit      (cfg_bit),
        .cfg_shift    (cfg_shift),
        .cfg_commit   (cfg_commit),
        .ovr_clr      (ovr_clr),
        .rd_valid     (rd_valid),
        .rd_ch        (rd_ch),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .sum_data     (sum_data),
        .sum_valid    (sum_valid),
        .sum_ready    (sum_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always @(posedge clk) if (rd_valid) rd_data <= mem[rd_ch][rd_idx];

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_sum();
        int s = 0;
        for (int c = 0; c < NUM_CH; c++) s += int'(mem[c][frame_dly[c]]);
`ifdef BEAM_SUM_AVG_EN
        s = s >>> CH_W;
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        if (rd_valid) check("rd_idx", rd_idx, frame_dly[rd_ch]);
        if (sum_valid && sum_ready) begin
            if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
            else check("sum", sum_data, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(int base);
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < BUFFER_SIZE; i++) mem[c][i] = 16'(base + c * 8 + i);
    endtask

    task automatic shift_dly(int ch, int v);
        for (int b = IDX_W - 1; b >= 0; b--) begin
            cfg_sel = CH_W'(ch);
            cfg_bit = v[b];
            cfg_shift = 1;
            tick();
        end
        cfg_shift = 0;
        shd[ch] = v;
    endtask

    task automatic commit();
        cfg_commit = 1;
        act = shd;
        tick();
        cfg_commit = 0;
    endtask

    task automatic strobe(bit with_commit);
        if (with_commit) begin
            cfg_commit = 1;
            act = shd;
        end
        frame_strobe = 1;
        frame_dly = act;
        sb.push_back(exp_sum());
        tick();
        frame_strobe = 0;
        cfg_commit = 0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (busy) check("timeout_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            shd[c] = 0;
            act[c] = 0;
            frame_dly[c] = 0;
        end
        fill(1000);
        repeat (2) tick();
        reset = 0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", sum_valid, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sum", sum_data, 0);
        // basic frame, delays {0,1,2,3}, latency T+NUM_CH+2
        mem[0][0] = 100; mem[1][1] = -50; mem[2][2] = 25; mem[3][3] = -5;
        for (int c = 0; c < NUM_CH; c++) shift_dly(c, c);
        commit();
        strobe(0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("lat_early", sum_valid, 0);
        @(negedge clk);
        check("lat_valid", sum_valid, 1);
        check("sum_basic", sum_data, EXP1);
        wait_idle();
        // full-scale negative samples, no wrap
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < BUFFER_SIZE; i++) mem[c][i] = -16'sd32768;
        strobe(0);
        wait_idle();
        // backpressure in OUT, dropped strobe, set beats clear
        fill(-300);
        sum_ready = 0;
        strobe(0);
        for (int n = 0; n < 20 && !sum_valid; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", sum_valid, 1);
            check("hold_data", sum_data, sb[0]);
            if (k >= 2) check("ovr_set", overrun, 1);
            frame_strobe = (k == 1 || k == 2);
            ovr_clr = (k == 2);
            @(negedge clk);
        end
        frame_strobe = 0;
        ovr_clr = 0;
        @(posedge clk);
        #1 sum_ready = 1;
        wait_idle();
        repeat (3) begin
            @(negedge clk);
            check("no_frame2", busy, 0);
        end
        check("sb_empty", sb.size(), 0);
        check("ovr_sticky", overrun, 1);
        ovr_clr = 1;
        tick();
        ovr_clr = 0;
        @(negedge clk);
        check("ovr_clr", overrun, 0);
        // commit mid-frame is deferred until IDLE
        fill(50);
        shift_dly(1, 5);
        strobe(0);
        tick();
        cfg_commit = 1;
        tick();
        cfg_commit = 0;
        wait_idle();
        act = shd;
        strobe(0);
        wait_idle();
        // reset in DRAIN clears the frame and config
        strobe(0);
        repeat (4) tick();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        check("rstd_busy", busy, 0);
        check("rstd_valid", sum_valid, 0);
        check("rstd_overrun", overrun, 0);
        sb.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            shd[c] = 0;
            act[c] = 0;
        end
        strobe(0);
        wait_idle();
        // commit and strobe together: frame uses new delays
        shift_dly(0, 7); shift_dly(1, 6); shift_dly(2, 5); shift_dly(3, 4);
        strobe(1);
        @(negedge clk);
        check("first_idx", rd_idx, 7);
        wait_idle();
        // random frames
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int i = 0; i < BUFFER_SIZE; i++) mem[c][i] = 16'($urandom);
            for (int c = 0; c < NUM_CH; c++) shift_dly(c, int'($urandom_range(0, BUFFER_SIZE - 1)));
            commit();
            strobe(0);
            wait_idle();
        end
        check("sb_final", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
